// File: rtl/id_entry_pkg.sv
// Shared types for the keypad entry and 7-segment scan blocks.
package id_pkg;

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} kp_state_t;

  localparam int NDIGITS = 4;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/id_entry_kp_debounce.sv
// Keypad debounce FSM: emits a one-cycle press strobe after DEBOUNCE stable high samples.
module kp_debounce
  import id_pkg::*;
#(
  parameter int DEBOUNCE = 1_000_000
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      kpvalid,
  input  bcd_t      kpnum,
  output logic      press,
  output bcd_t      code,
  output kp_state_t state
);

  localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE - 1);

  kp_state_t   state_n;
  logic [19:0] cnt;
  logic [19:0] cnt_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // press is combinational so the write lands on the same edge that enters HELD.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press   = 1'b0;
    case (state)
      IDLE: begin
        if (kpvalid) begin
          state_n = PRESS;
          cnt_n   = 20'd1;
        end
      end
      PRESS: begin
        if (!kpvalid) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = HELD;
          cnt_n   = '0;
          press   = 1'b1;
        end else begin
          cnt_n = cnt + 20'd1;
        end
      end
      HELD: begin
        if (!kpvalid) begin
          state_n = RELEASE;
          cnt_n   = 20'd1;
        end
      end
      RELEASE: begin
        // Going high again here is release bounce: back to HELD, no new strobe.
        if (kpvalid) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 20'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign code = kpnum;

endmodule

// File: rtl/id_entry.sv
// Student-ID entry register: stores up to four debounced keypad digits and flags a match.
module id_entry
  import id_pkg::*;
#(
  parameter int          DEBOUNCE = 1_000_000,
  parameter logic [15:0] EXPECTED = 16'h4800
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       kpvalid,
  input  logic [3:0] kpnum,
  input  logic       clear,
  input  logic [1:0] digit,
  output logic [3:0] idnum,
  output logic [2:0] count,
  output logic       full,
  output logic       match,
  output logic       accepted
);

  bcd_t      slot [NDIGITS];
  logic      press;
  bcd_t      code;
  kp_state_t kp_state;
  logic      accept;

  kp_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .kpvalid (kpvalid),
    .kpnum   (kpnum),
    .press   (press),
    .code    (code),
    .state   (kp_state)
  );

  assign full   = (count == 3'(NDIGITS));
  assign accept = press && (code <= 4'd9) && (count < 3'(NDIGITS));

  // clear outranks a simultaneous accept; the debounce FSM is left alone on clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NDIGITS; i++) slot[i] <= '0;
      count    <= '0;
      accepted <= 1'b0;
      match    <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NDIGITS; i++) slot[i] <= '0;
      count    <= '0;
      accepted <= 1'b0;
      match    <= 1'b0;
    end else begin
      accepted <= accept;
      match    <= full && ({slot[0], slot[1], slot[2], slot[3]} == EXPECTED);
      if (accept) begin
        slot[count[1:0]] <= code;
        count            <= count + 3'd1;
      end
    end
  end

  assign idnum = slot[digit];

endmodule

// File: tb/tb_id_entry.sv
// Directed bench for id_entry with DEBOUNCE=4 and EXPECTED=16'h4800.
module tb_id_entry;

  logic       clk;
  logic       reset_n;
  logic       kpvalid;
  logic [3:0] kpnum;
  logic       clear;
  logic [1:0] digit;
  logic [3:0] idnum;
  logic [2:0] count;
  logic       full;
  logic       match;
  logic       accepted;

  int tests = 0;
  int fails = 0;
  int acc_n;
  int acc_at;
  int total;
  logic m_at;
  logic m_next;

  id_entry #(
    .DEBOUNCE (4),
    .EXPECTED (16'h4800)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .kpvalid  (kpvalid),
    .kpnum    (kpnum),
    .clear    (clear),
    .digit    (digit),
    .idnum    (idnum),
    .count    (count),
    .full     (full),
    .match    (match),
    .accepted (accepted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_read(input string tag, input logic [1:0] d, input logic [3:0] exp);
    digit = d;
    #1;
    check(tag, 16'(idnum), 16'(exp));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count"}, 16'(count), 16'h0);
    check({tag, "_full"}, 16'(full), 16'h0);
    check({tag, "_match"}, 16'(match), 16'h0);
    check({tag, "_accepted"}, 16'(accepted), 16'h0);
    for (int d = 0; d < 4; d++) check_read({tag, "_idnum"}, 2'(d), 4'h0);
  endtask

  // Hold key k for 'hold' edges then release for 'rel' edges, recording accept pulses.
  task automatic key(input logic [3:0] k, input int hold, input int rel);
    acc_n  = 0;
    acc_at = 0;
    m_at   = 1'bx;
    m_next = 1'bx;
    kpvalid = 1'b1;
    kpnum   = k;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (acc_n > 0 && i == acc_at + 1) m_next = match;
      if (accepted) begin
        acc_n++;
        acc_at = i;
        m_at   = match;
      end
    end
    kpvalid = 1'b0;
    kpnum   = 4'hf;
    for (int i = 1; i <= rel; i++) begin
      tick();
      if (acc_n > 0 && hold + i == acc_at + 1) m_next = match;
      if (accepted) acc_n++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    kpvalid = 1'b0;
    kpnum   = 4'h0;
    clear   = 1'b0;
    digit   = 2'd0;
    tick();
    tick();
    check_zero("por");
    reset_n = 1'b1;
    tick();

    // Clean entry 4,8,0,0: accept on the 4th edge after kpvalid rises.
    key(4'd4, 6, 6);
    check("e1_acc_n", 16'(acc_n), 16'd1);
    check("e1_acc_at", 16'(acc_at), 16'd4);
    check("e1_count", 16'(count), 16'd1);
    key(4'd8, 6, 6);
    check("e2_acc_n", 16'(acc_n), 16'd1);
    check("e2_acc_at", 16'(acc_at), 16'd4);
    check("e2_count", 16'(count), 16'd2);
    key(4'd0, 6, 6);
    check("e3_acc_n", 16'(acc_n), 16'd1);
    check("e3_count", 16'(count), 16'd3);
    check("e3_match", 16'(match), 16'd0);
    key(4'd0, 6, 6);
    check("e4_acc_n", 16'(acc_n), 16'd1);
    check("e4_acc_at", 16'(acc_at), 16'd4);
    check("e4_match_at_write", 16'(m_at), 16'd0);
    check("e4_match_next", 16'(m_next), 16'd1);
    check("e4_count", 16'(count), 16'd4);
    check("e4_full", 16'(full), 16'd1);
    check("e4_match", 16'(match), 16'd1);
    check_read("e_rd0", 2'd0, 4'd4);
    check_read("e_rd1", 2'd1, 4'd8);
    check_read("e_rd2", 2'd2, 4'd0);
    check_read("e_rd3", 2'd3, 4'd0);

    // Clear drops full and match on the same edge and zeroes the slots.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_full", 16'(full), 16'd0);
    check("clr_match", 16'(match), 16'd0);
    check("clr_count", 16'(count), 16'd0);
    check_read("clr_rd0", 2'd0, 4'd0);
    check_read("clr_rd1", 2'd1, 4'd0);

    // Reset in the middle of a press, with one digit already stored.
    key(4'd9, 6, 6);
    check("pre_rst_count", 16'(count), 16'd1);
    kpvalid = 1'b1;
    kpnum   = 4'd7;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    tick();
    reset_n = 1'b1;
    key(4'd7, 6, 6);
    check("rst_hold_acc_n", 16'(acc_n), 16'd1);
    check("rst_hold_acc_at", 16'(acc_at), 16'd4);
    check("rst_hold_count", 16'(count), 16'd1);
    check_read("rst_hold_rd0", 2'd0, 4'd7);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Bounce rejection: short glitches, then one press with release dropouts.
    total = 0;
    key(4'd3, 2, 4);
    total += acc_n;
    key(4'd3, 3, 4);
    total += acc_n;
    check("glitch_count", 16'(count), 16'd0);
    key(4'd3, 5, 1);
    total += acc_n;
    key(4'd3, 1, 1);
    total += acc_n;
    key(4'd3, 1, 6);
    total += acc_n;
    check("bounce_total", 16'(total), 16'd1);
    check("bounce_count", 16'(count), 16'd1);
    check_read("bounce_rd0", 2'd0, 4'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Invalid code and overflow.
    key(4'hb, 6, 6);
    check("keyb_acc_n", 16'(acc_n), 16'd0);
    check("keyb_count", 16'(count), 16'd0);
    key(4'd1, 6, 6);
    key(4'd2, 6, 6);
    key(4'd3, 6, 6);
    key(4'd4, 6, 6);
    check("ov_count4", 16'(count), 16'd4);
    key(4'd5, 6, 6);
    check("ov_acc_n", 16'(acc_n), 16'd0);
    check("ov_count", 16'(count), 16'd4);
    check("ov_full", 16'(full), 16'd1);
    check("ov_match", 16'(match), 16'd0);
    check_read("ov_rd0", 2'd0, 4'd1);
    check_read("ov_rd1", 2'd1, 4'd2);
    check_read("ov_rd2", 2'd2, 4'd3);
    check_read("ov_rd3", 2'd3, 4'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Clear on the accept edge: digit dropped, held key not re-accepted.
    kpvalid = 1'b1;
    kpnum   = 4'd6;
    tick();
    tick();
    tick();
    check("col_pre_acc", 16'(accepted), 16'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("col_count", 16'(count), 16'd0);
    check("col_accepted", 16'(accepted), 16'd0);
    check("col_match", 16'(match), 16'd0);
    total = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (accepted) total++;
    end
    kpvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (accepted) total++;
    end
    check("col_hold_acc", 16'(total), 16'd0);
    check("col_hold_count", 16'(count), 16'd0);
    key(4'd6, 6, 6);
    check("col_repress_acc", 16'(acc_n), 16'd1);
    check("col_repress_count", 16'(count), 16'd1);
    check_read("col_repress_rd0", 2'd0, 4'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
